// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch unit: fetch states, reset-vector
// location and the opcode-to-length rule (also usable by the core for PC+len).
package ifetch_pkg;

  typedef enum logic [3:0] {
    S_RST,
    S_VLO,
    S_VHI,
    S_VCAP,
    S_FETCH,
    S_DEC,
    S_OP1,
    S_OP2,
    S_OUT
  } fetch_state_e;

  localparam logic [15:0] RESET_VEC_DEFAULT = 16'hFFFC;

  // First match wins: the 1-byte group must be tested before the 3-byte group.
  function automatic logic [1:0] opcode_len(input logic [7:0] op);
    logic [1:0] len;
    if (op == 8'h40 || op == 8'h60 || op ==? 8'b???_?10_?0) begin
      len = 2'd1;
    end else if (op == 8'h20 || op ==? 8'b???_011_?? ||
                 op ==? 8'b???_110_?1 || op ==? 8'b???_111_??) begin
      len = 2'd3;
    end else begin
      len = 2'd2;
    end
    return len;
  endfunction

endpackage

// File: rtl/ifetch_insn_len.sv
// Combinational opcode sizer (1..3 bytes); shared with the core for pushes.
module ifetch_insn_len
  import ifetch_pkg::*;
(
  input  logic [7:0] opcode_i,
  output logic [1:0] len_o
);

  assign len_o = opcode_len(opcode_i);

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: loads PC from the reset vector, assembles 1-3 byte
// instructions from a 1-cycle-latency byte memory and hands them to the core.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [15:0] RESET_VEC = RESET_VEC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        mem_rd_o,
  output logic [15:0] mem_addr_o,
  input  logic [7:0]  mem_rdata_i,
  output logic        insn_valid_o,
  input  logic        insn_ready_i,
  output logic [7:0]  insn_opcode_o,
  output logic [15:0] insn_operand_o,
  output logic [1:0]  insn_len_o,
  output logic [15:0] insn_pc_o,
  input  logic        redirect_i,
  input  logic [15:0] redirect_pc_i
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic         valid_q, valid_d;
  logic [7:0]   opcode_q, opcode_d;
  logic [15:0]  operand_q, operand_d;
  logic [1:0]   len_q, len_d;
  logic [15:0]  ipc_q, ipc_d;
  logic [1:0]   dec_len;
  logic         xfer;
  logic         redir_act;

  ifetch_insn_len u_insn_len (
    .opcode_i (mem_rdata_i),
    .len_o    (dec_len)
  );

  assign xfer = valid_q && insn_ready_i;

  // The vector load cannot be interrupted; redirects only act once a PC exists.
  always_comb begin
    redir_act = 1'b0;
    if (redirect_i) begin
      unique case (state_q)
        S_FETCH, S_DEC, S_OP1, S_OP2, S_OUT: redir_act = 1'b1;
        default:                             redir_act = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    opcode_d   = opcode_q;
    operand_d  = operand_q;
    len_d      = len_q;
    ipc_d      = ipc_q;
    mem_rd_o   = 1'b0;
    mem_addr_o = 16'h0000;

    unique case (state_q)
      S_RST: state_d = S_VLO;
      S_VLO: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = RESET_VEC;
        state_d    = S_VHI;
      end
      S_VHI: begin
        pc_d[7:0]  = mem_rdata_i;
        mem_rd_o   = 1'b1;
        mem_addr_o = RESET_VEC + 16'd1;
        state_d    = S_VCAP;
      end
      S_VCAP: begin
        pc_d[15:8] = mem_rdata_i;
        state_d    = S_FETCH;
      end
      S_FETCH: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = pc_q;
        state_d    = S_DEC;
      end
      S_DEC: begin
        opcode_d  = mem_rdata_i;
        len_d     = dec_len;
        ipc_d     = pc_q;
        operand_d = 16'h0000;
        if (dec_len != 2'd1) begin
          mem_rd_o   = 1'b1;
          mem_addr_o = pc_q + 16'd1;
          state_d    = S_OP1;
        end else begin
          state_d = S_OUT;
        end
      end
      S_OP1: begin
        operand_d[7:0] = mem_rdata_i;
        if (len_q == 2'd3) begin
          mem_rd_o   = 1'b1;
          mem_addr_o = pc_q + 16'd2;
          state_d    = S_OP2;
        end else begin
          state_d = S_OUT;
        end
      end
      S_OP2: begin
        operand_d[15:8] = mem_rdata_i;
        state_d         = S_OUT;
      end
      S_OUT: begin
        // Back-to-back: the next opcode read overlaps the transfer cycle.
        if (xfer) begin
          pc_d       = pc_q + {14'b0, len_q};
          mem_rd_o   = 1'b1;
          mem_addr_o = pc_q + {14'b0, len_q};
          state_d    = S_DEC;
        end
      end
      default: state_d = S_RST;
    endcase

    if (redir_act) begin
      pc_d       = redirect_pc_i;
      mem_rd_o   = 1'b1;
      mem_addr_o = redirect_pc_i;
      state_d    = S_DEC;
    end

    valid_d = (state_d == S_OUT);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_RST;
      pc_q      <= 16'h0000;
      valid_q   <= 1'b0;
      opcode_q  <= 8'h00;
      operand_q <= 16'h0000;
      len_q     <= 2'd1;
      ipc_q     <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      len_q     <= len_d;
      ipc_q     <= ipc_d;
    end
  end

  assign insn_valid_o   = valid_q;
  assign insn_opcode_o  = opcode_q;
  assign insn_operand_o = operand_q;
  assign insn_len_o     = len_q;
  assign insn_pc_o      = ipc_q;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed start-up/stream/edge scenarios, then random
// ready/redirect traffic checked against an instruction-level model.
`timescale 1ns/1ps
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        insn_valid;
  logic        insn_ready = 1'b0;
  logic [7:0]  insn_opcode;
  logic [15:0] insn_operand;
  logic [1:0]  insn_len;
  logic [15:0] insn_pc;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;

  logic [7:0]  mem [0:65535];
  int          n_chk = 0;
  int          n_err = 0;

  logic [7:0]  sw_op  [12] = '{8'h18, 8'h40, 8'h60, 8'h9A, 8'h00, 8'hA9,
                               8'hD0, 8'hB1, 8'h20, 8'h6C, 8'hBD, 8'hB9};
  int          sw_len [12] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3};

  always #5 clk = ~clk;

  ifetch #(.RESET_VEC(16'hFFFC)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .mem_rd_o       (mem_rd),
    .mem_addr_o     (mem_addr),
    .mem_rdata_i    (mem_rdata),
    .insn_valid_o   (insn_valid),
    .insn_ready_i   (insn_ready),
    .insn_opcode_o  (insn_opcode),
    .insn_operand_o (insn_operand),
    .insn_len_o     (insn_len),
    .insn_pc_o      (insn_pc),
    .redirect_i     (redirect),
    .redirect_pc_i  (redirect_pc)
  );

  // Byte memory with fixed 1-cycle read latency.
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Instruction length from the opcode classes (mode = bits 4:2, group = bits 1:0).
  function automatic int ref_len(input logic [7:0] op);
    int mode, grp;
    mode = int'(op[4:2]);
    grp  = int'(op[1:0]);
    if (op == 8'h40 || op == 8'h60) return 1;
    if ((mode == 2 || mode == 6) && (grp % 2 == 0)) return 1;
    if (op == 8'h20 || mode == 3 || mode == 7 || (mode == 6 && grp % 2 == 1)) return 3;
    return 2;
  endfunction

  task automatic expect_at(input string tag, input logic [15:0] p);
    logic [15:0] a1, a2, opnd;
    int l;
    a1 = p + 16'd1;
    a2 = p + 16'd2;
    l  = ref_len(mem[p]);
    if (l == 1)      opnd = 16'h0000;
    else if (l == 2) opnd = {8'h00, mem[a1]};
    else             opnd = {mem[a2], mem[a1]};
    chk({tag, ".pc"},   64'(insn_pc),      64'(p));
    chk({tag, ".op"},   64'(insn_opcode),  64'(mem[p]));
    chk({tag, ".opnd"}, 64'(insn_operand), 64'(opnd));
    chk({tag, ".len"},  64'(insn_len),     64'(l));
  endtask

  task automatic reset_to(input logic [15:0] vec);
    mem[16'hFFFC] = vec[7:0];
    mem[16'hFFFD] = vec[15:8];
    insn_ready = 1'b1;
    redirect   = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns at the negedge before a transfer edge; bounded.
  task automatic wait_xfer(input string tag, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (insn_valid && insn_ready) ok = 1'b1;
    end
    if (!ok) chk({tag, ".timeout"}, 64'(0), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int          xc [$];
    logic [63:0] xo [$];
    logic        ok;
    logic [15:0] a, exp_pc;
    logic [7:0]  h_op;
    logic [15:0] h_opnd, h_pc;
    logic [1:0]  h_len;
    logic        hold_prev;
    int          nx;

    for (int i = 0; i < 65536; i++) mem[16'(i)] = 8'hEA;

    // Reset state
    #1 rst_n = 1'b0;
    #10;
    chk("rst.mem_rd",  64'(mem_rd),       64'(0));
    chk("rst.addr",    64'(mem_addr),     64'(0));
    chk("rst.valid",   64'(insn_valid),   64'(0));
    chk("rst.opcode",  64'(insn_opcode),  64'(0));
    chk("rst.operand", 64'(insn_operand), 64'(0));
    chk("rst.len",     64'(insn_len),     64'(1));
    chk("rst.pc",      64'(insn_pc),      64'(0));

    // Reset vector and a short stream with ready held high
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42;
    mem[16'h8002] = 8'h4C; mem[16'h8003] = 8'h34; mem[16'h8004] = 8'h12;
    mem[16'h8005] = 8'hEA;
    insn_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #2;
      if (k == 1) chk("vec.c1", 64'({mem_rd, mem_addr}), 64'({1'b1, 16'hFFFC}));
      if (k == 2) chk("vec.c2", 64'({mem_rd, mem_addr}), 64'({1'b1, 16'hFFFD}));
      if (k == 3) chk("vec.c3", 64'(mem_rd), 64'(0));
      if (k == 4) chk("vec.c4", 64'({mem_rd, mem_addr}), 64'({1'b1, 16'h8000}));
      if (insn_valid) begin
        xc.push_back(k);
        xo.push_back(64'({insn_opcode, insn_operand, insn_len, insn_pc}));
      end
    end
    chk("stream.count", 64'(xc.size() >= 3), 64'(1));
    if (xc.size() >= 3) begin
      chk("stream.x0", xo[0], 64'({8'hA9, 16'h0042, 2'd2, 16'h8000}));
      chk("stream.x1", xo[1], 64'({8'h4C, 16'h1234, 2'd3, 16'h8002}));
      chk("stream.x2", xo[2], 64'({8'hEA, 16'h0000, 2'd1, 16'h8005}));
      chk("stream.first_valid", 64'(xc[0]), 64'(7));
      chk("stream.gap1", 64'(xc[1] - xc[0]), 64'(4));
      chk("stream.gap2", 64'(xc[2] - xc[1]), 64'(2));
    end

    // Length sweep, packed back to back at 9000
    a = 16'h9000;
    for (int i = 0; i < 12; i++) begin
      mem[a] = sw_op[i];
      a = a + 16'(sw_len[i]);
    end
    reset_to(16'h9000);
    a = 16'h9000;
    for (int i = 0; i < 12; i++) begin
      wait_xfer("sweep", ok);
      if (ok) begin
        chk($sformatf("sweep.len.%02h", sw_op[i]), 64'(insn_len), 64'(sw_len[i]));
        chk($sformatf("sweep.op.%02h", sw_op[i]), 64'(insn_opcode), 64'(sw_op[i]));
        chk($sformatf("sweep.pc.%02h", sw_op[i]), 64'(insn_pc), 64'(a));
      end
      a = a + 16'(sw_len[i]);
    end

    // Backpressure
    reset_to(16'h8000);
    insn_ready = 1'b0;
    for (int i = 0; i < 32 && !insn_valid; i++) @(negedge clk);
    chk("bp.valid", 64'(insn_valid), 64'(1));
    h_op = insn_opcode; h_opnd = insn_operand; h_len = insn_len; h_pc = insn_pc;
    chk("bp.first", 64'({h_op, h_opnd, h_len, h_pc}), 64'({8'hA9, 16'h0042, 2'd2, 16'h8000}));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.hold", 64'({insn_valid, insn_opcode, insn_operand, insn_len, insn_pc}),
          64'({1'b1, h_op, h_opnd, h_len, h_pc}));
      chk("bp.no_rd", 64'(mem_rd), 64'(0));
    end
    insn_ready = 1'b1;
    #1;
    chk("bp.release_rd", 64'({mem_rd, mem_addr}), 64'({1'b1, 16'h8002}));
    wait_xfer("bp.next", ok);
    if (ok) chk("bp.next.pc", 64'(insn_pc), 64'(16'h8002));

    // Redirect while in OP1 of the first instruction
    mem[16'h1234] = 8'hA9; mem[16'h1235] = 8'h77;
    reset_to(16'h8000);
    repeat (6) @(posedge clk);
    #1;
    redirect = 1'b1; redirect_pc = 16'h1234;
    #1;
    chk("redir.rd", 64'({mem_rd, mem_addr}), 64'({1'b1, 16'h1234}));
    @(posedge clk); #1;
    redirect = 1'b0;
    wait_xfer("redir", ok);
    if (ok) chk("redir.x", 64'({insn_opcode, insn_operand, insn_len, insn_pc}),
                64'({8'hA9, 16'h0077, 2'd2, 16'h1234}));

    // Redirect during the vector load is ignored
    reset_to(16'h8000);
    repeat (2) @(posedge clk);
    #1;
    redirect = 1'b1; redirect_pc = 16'h5555;
    @(posedge clk); #1;
    redirect = 1'b0;
    wait_xfer("redir_vhi", ok);
    if (ok) chk("redir_vhi.pc", 64'(insn_pc), 64'(16'h8000));

    // PC wrap on a 3-byte opcode at FFFF
    mem[16'hFFFF] = 8'h4C; mem[16'h0000] = 8'h11; mem[16'h0001] = 8'h22;
    mem[16'h0002] = 8'hEA;
    reset_to(16'hFFFF);
    wait_xfer("wrap", ok);
    if (ok) chk("wrap.x", 64'({insn_opcode, insn_operand, insn_len, insn_pc}),
                64'({8'h4C, 16'h2211, 2'd3, 16'hFFFF}));
    wait_xfer("wrap.next", ok);
    if (ok) chk("wrap.next.pc", 64'(insn_pc), 64'(16'h0002));

    // Asynchronous reset during OP2
    reset_to(16'hFFFF);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("areset.valid",  64'(insn_valid),  64'(0));
    chk("areset.rd",     64'(mem_rd),      64'(0));
    chk("areset.opcode", 64'(insn_opcode), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("areset.vec1", 64'({mem_rd, mem_addr}), 64'({1'b1, 16'hFFFC}));
    @(posedge clk); #2;
    chk("areset.vec2", 64'({mem_rd, mem_addr}), 64'({1'b1, 16'hFFFD}));
    wait_xfer("areset.x", ok);
    if (ok) chk("areset.x.pc", 64'(insn_pc), 64'(16'hFFFF));

    // Random traffic against the instruction-level model
    for (int i = 0; i < 65536; i++) mem[16'(i)] = 8'($urandom);
    reset_to(16'h4000);
    repeat (3) @(posedge clk);
    exp_pc    = 16'h4000;
    hold_prev = 1'b0;
    nx        = 0;
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk); #1;
      insn_ready  = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_pc = 16'($urandom);
      @(negedge clk);
      if (hold_prev)
        chk("rnd.hold", 64'({insn_valid, insn_opcode, insn_operand, insn_len, insn_pc}),
            64'({1'b1, h_op, h_opnd, h_len, h_pc}));
      hold_prev = 1'b0;
      if (insn_valid && insn_ready) begin
        expect_at("rnd", exp_pc);
        nx++;
        if (redirect) begin
          exp_pc = redirect_pc;
        end else begin
          exp_pc = exp_pc + 16'(ref_len(mem[exp_pc]));
          chk("rnd.next_rd", 64'({mem_rd, mem_addr}), 64'({1'b1, exp_pc}));
        end
      end else if (redirect) begin
        exp_pc = redirect_pc;
      end else if (insn_valid) begin
        chk("rnd.hold_rd", 64'(mem_rd), 64'(0));
        hold_prev = 1'b1;
        h_op = insn_opcode; h_opnd = insn_operand; h_len = insn_len; h_pc = insn_pc;
      end
    end
    redirect = 1'b0;
    chk("rnd.progress", 64'(nx > 100), 64'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
